hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard unit for a 5-stage pipeline with a multi-cycle multiply.
//
// Ports:
//   clk, reset (async, active-low)
//   RA1D/RA2D   decode source registers     RA1E/RA2E  execute source registers
//   WA3E/M/W    destination registers       RegWriteE/M/W  write enables
//   MemtoRegE   E-stage load                PCSrcD/E/M/W   PC write in flight
//   BranchTakenE, MulStartE
//   ForwardAE/BE  operand select (00 regfile, 01 W, 10 M)
//   StallF/D/E, FlushD/E, Busy (multiply in E), StallCount (saturating)
module hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  RA1D,
  input  logic [3:0]  RA2D,
  input  logic [3:0]  RA1E,
  input  logic [3:0]  RA2E,
  input  logic [3:0]  WA3E,
  input  logic [3:0]  WA3M,
  input  logic [3:0]  WA3W,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        PCSrcD,
  input  logic        PCSrcE,
  input  logic        PCSrcM,
  input  logic        PCSrcW,
  input  logic        BranchTakenE,
  input  logic        MulStartE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        Busy,
  output logic [15:0] StallCount
);

  typedef enum logic {RUN = 1'b0, MUL_BUSY = 1'b1} state_t;

  // Busy lasts MUL_LAT-1 cycles: the cycle MulStartE is seen counts as the first.
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        busy_reg;
  logic [15:0] stall_count_reg;

  logic ldstall;
  logic pcpend;

  // M result is younger than W, so it wins; r15 is the PC and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic       wr_m,
                                         input logic [3:0] wa_m,
                                         input logic       wr_w,
                                         input logic [3:0] wa_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != 4'hF) begin
      if (wr_m && (ra == wa_m))      sel = 2'b10;
      else if (wr_w && (ra == wa_w)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
  assign ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);

  assign ldstall = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pcpend  = PCSrcD | PCSrcE | PCSrcM;

  assign Busy       = busy_reg;
  assign StallF     = ldstall | pcpend | busy_reg;
  assign StallD     = ldstall | busy_reg;
  assign StallE     = busy_reg;
  // A multiply holding E freezes the pipe; flushing around it would lose instructions.
  assign FlushD     = ~busy_reg & (pcpend | PCSrcW | BranchTakenE);
  assign FlushE     = ~busy_reg & (ldstall | BranchTakenE);
  assign StallCount = stall_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
      cnt_reg   <= 4'd0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          // A taken branch squashes the multiply that entered E with it.
          if (MulStartE && !BranchTakenE) begin
            state_reg <= MUL_BUSY;
            cnt_reg   <= CNT_LOAD;
            busy_reg  <= 1'b1;
          end
        end
        MUL_BUSY: begin
          if (cnt_reg == 4'd1) begin
            state_reg <= RUN;
            cnt_reg   <= 4'd0;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= RUN;
          cnt_reg   <= 4'd0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_reg <= 16'd0;
    end else if (StallF && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, Busy;
  logic [15:0] StallCount;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .Busy(Busy), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  typedef enum {S_FWA, S_FWB, S_STF, S_STD, S_STE, S_FLD, S_FLE, S_BUSY, S_CNT} sig_e;
  typedef struct {
    sig_e        sig;
    logic [15:0] exp;
    string       tag;
  } sb_t;
  sb_t sb_q[$];

  function automatic logic [15:0] observe(sig_e s);
    case (s)
      S_FWA:  return {14'd0, ForwardAE};
      S_FWB:  return {14'd0, ForwardBE};
      S_STF:  return {15'd0, StallF};
      S_STD:  return {15'd0, StallD};
      S_STE:  return {15'd0, StallE};
      S_FLD:  return {15'd0, FlushD};
      S_FLE:  return {15'd0, FlushE};
      S_BUSY: return {15'd0, Busy};
      default: return StallCount;
    endcase
  endfunction

  task automatic push(input sig_e s, input logic [15:0] e, input string tag);
    sb_t item;
    item.sig = s;
    item.exp = e;
    item.tag = tag;
    sb_q.push_back(item);
  endtask

  task automatic push_ctl(input logic stf, input logic std, input logic ste,
                          input logic fld, input logic fle, input logic bsy,
                          input string tag);
    push(S_STF,  {15'd0, stf}, {tag, ".StallF"});
    push(S_STD,  {15'd0, std}, {tag, ".StallD"});
    push(S_STE,  {15'd0, ste}, {tag, ".StallE"});
    push(S_FLD,  {15'd0, fld}, {tag, ".FlushD"});
    push(S_FLE,  {15'd0, fle}, {tag, ".FlushE"});
    push(S_BUSY, {15'd0, bsy}, {tag, ".Busy"});
  endtask

  // Pops every pending expectation and compares it against the live output.
  task automatic check_all();
    sb_t item;
    logic [15:0] obs;
    while (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      obs = observe(item.sig);
      checks++;
      assert (obs === item.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", item.tag, obs, item.exp);
      end
      $display("check %s: observed %0h expected %0h", item.tag, obs, item.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd9; WA3M = 4'd10; WA3W = 4'd11;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b0; MulStartE = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #2;
    // Reset state, no clock needed
    push(S_CNT, 16'd0, "rst.StallCount");
    push_ctl(0, 0, 0, 0, 0, 0, "rst");
    check_all();
    // Combinational outputs live during reset
    PCSrcD = 1'b1;
    #1;
    push_ctl(1, 0, 0, 1, 0, 0, "rst_comb");
    check_all();
    tick();
    tick();
    push(S_CNT, 16'd0, "rst_hold.StallCount");
    check_all();
    PCSrcD = 1'b0;
    reset = 1'b1;
    #1;

    // Forwarding
    RegWriteM = 1'b1; WA3M = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3; RA1E = 4'd3; RA2E = 4'd3;
    #1;
    push(S_FWA, 16'd2, "fwdA_M");
    push(S_FWB, 16'd2, "fwdB_M");
    check_all();
    RegWriteM = 1'b0;
    #1;
    push(S_FWA, 16'd1, "fwdA_W");
    push(S_FWB, 16'd1, "fwdB_W");
    check_all();
    RegWriteM = 1'b1; RA1E = 4'hF; WA3M = 4'hF; WA3W = 4'hF; RA2E = 4'd7;
    #1;
    push(S_FWA, 16'd0, "fwdA_pc");
    push(S_FWB, 16'd0, "fwdB_nomatch");
    check_all();

    // Load-use stall
    tick();
    clear_inputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    #1;
    push_ctl(1, 1, 0, 0, 1, 0, "ldstall");
    push(S_CNT, 16'd0, "ldstall.StallCount");
    check_all();
    tick();
    clear_inputs();
    #1;
    push_ctl(0, 0, 0, 0, 0, 0, "ldstall_end");
    push(S_CNT, 16'd1, "ldstall_end.StallCount");
    check_all();

    // Multiply: three busy cycles, branch and new multiply ignored meanwhile
    tick();
    MulStartE = 1'b1;
    #1;
    push_ctl(0, 0, 0, 0, 0, 0, "mul_start");
    check_all();
    tick();
    MulStartE = 1'b0;
    #1;
    push_ctl(1, 1, 1, 0, 0, 1, "mul_b1");
    check_all();
    tick();
    BranchTakenE = 1'b1;
    #1;
    push_ctl(1, 1, 1, 0, 0, 1, "mul_b2_branch");
    check_all();
    tick();
    BranchTakenE = 1'b0;
    MulStartE = 1'b1;
    #1;
    push_ctl(1, 1, 1, 0, 0, 1, "mul_b3");
    check_all();
    tick();
    MulStartE = 1'b0;
    #1;
    push_ctl(0, 0, 0, 0, 0, 0, "mul_done");
    push(S_CNT, 16'd4, "mul_done.StallCount");
    check_all();
    tick();
    #1;
    push(S_BUSY, 16'd0, "mul_ignored.Busy");
    check_all();

    // Branch beats a simultaneous multiply
    MulStartE = 1'b1; BranchTakenE = 1'b1;
    #1;
    push_ctl(0, 0, 0, 1, 1, 0, "mul_branch");
    check_all();
    tick();
    clear_inputs();
    #1;
    push(S_BUSY, 16'd0, "mul_branch_after.Busy");
    check_all();

    // PC writes walking down the pipe
    PCSrcD = 1'b1;
    #1;
    push_ctl(1, 0, 0, 1, 0, 0, "pc_D");
    check_all();
    tick();
    PCSrcD = 1'b0; PCSrcE = 1'b1;
    #1;
    push_ctl(1, 0, 0, 1, 0, 0, "pc_E");
    check_all();
    tick();
    PCSrcE = 1'b0; PCSrcM = 1'b1;
    #1;
    push_ctl(1, 0, 0, 1, 0, 0, "pc_M");
    check_all();
    tick();
    PCSrcM = 1'b0; PCSrcW = 1'b1;
    #1;
    push_ctl(0, 0, 0, 1, 0, 0, "pc_W");
    check_all();
    tick();
    PCSrcW = 1'b0;
    #1;
    push_ctl(0, 0, 0, 0, 0, 0, "pc_done");
    push(S_CNT, 16'd7, "pc_done.StallCount");
    check_all();

    // Asynchronous reset in the middle of a multiply
    MulStartE = 1'b1;
    tick();
    MulStartE = 1'b0;
    #1;
    push(S_BUSY, 16'd1, "mulrst_pre.Busy");
    check_all();
    #2;
    reset = 1'b0;
    #1;
    push_ctl(0, 0, 0, 0, 0, 0, "mulrst");
    push(S_CNT, 16'd0, "mulrst.StallCount");
    check_all();
    tick();
    reset = 1'b1;
    tick();
    push(S_BUSY, 16'd0, "mulrst_after.Busy");
    check_all();

    // Saturation of StallCount
    PCSrcD = 1'b1;
    repeat (65534) tick();
    push(S_CNT, 16'hFFFE, "sat_minus1");
    check_all();
    tick();
    push(S_CNT, 16'hFFFF, "sat_hit");
    check_all();
    repeat (4464) tick();
    push(S_CNT, 16'hFFFF, "sat_hold");
    check_all();
    PCSrcD = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
